// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a request/ready handshake with LATENCY wait states.
// Optional DMEM_BYTE_LANES_EN adds a byte_en port and per-lane write masking.
module data_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr_mem,
    input  logic [31:0] write_mem,
`ifdef DMEM_BYTE_LANES_EN
    input  logic [3:0]  byte_en,
`endif
    output logic [31:0] read_mem,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int unsigned LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    state_t              state, state_nx;
    logic [3:0]          cnt, cnt_nx;
    logic                op_wr;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         wdata;
    logic [3:0]          be_q;
    logic [3:0]          in_be;
    logic [31:0]         ram [2**ADDR_W];

    logic                accept, reject;
    logic                commit, c_wr;
    logic [ADDR_W-1:0]   c_idx;
    logic [31:0]         c_data;
    logic [3:0]          c_be;
    logic [ADDR_W-1:0]   in_idx;
    logic                unused_addr_bits;

`ifdef DMEM_BYTE_LANES_EN
    assign in_be = byte_en;
`else
    assign in_be = 4'hF;
`endif

    assign in_idx           = addr_mem[ADDR_W+1:2];
    assign unused_addr_bits = ^addr_mem[31:ADDR_W+2];

    assign accept = (state == IDLE) && (MemRead ^ MemWrite) && (addr_mem[1:0] == 2'b00);
    assign reject = (state == IDLE) &&
                    ((MemRead && MemWrite) || ((MemRead || MemWrite) && (addr_mem[1:0] != 2'b00)));

    // With zero latency the RAM is touched at the acceptance edge, so it must use live inputs.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        c_wr     = op_wr;
        c_idx    = idx;
        c_data   = wdata;
        c_be     = be_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nx = DONE;
                        commit   = 1'b1;
                        c_wr     = MemWrite;
                        c_idx    = in_idx;
                        c_data   = write_mem;
                        c_be     = in_be;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = LAT_M1[3:0];
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                    commit   = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_wr    <= 1'b0;
            idx      <= '0;
            wdata    <= '0;
            be_q     <= '0;
            read_mem <= '0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr_err <= reject;
            if (accept) begin
                op_wr <= MemWrite;
                idx   <= in_idx;
                wdata <= write_mem;
                be_q  <= in_be;
            end
            if (commit && !c_wr)
                read_mem <= ram[c_idx];
        end
    end

    // RAM contents survive reset; the rst_n gate keeps an access seen during reset from landing.
    always_ff @(posedge clk) begin
        if (rst_n && commit && c_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (c_be[i])
                    ram[c_idx][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    assign mem_ready = (state == DONE);
    assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 0 and 3.
module tb_data_mem_responder;

    logic        clk;
    logic        rst[3];
    logic        mr[3], mw[3];
    logic [31:0] addr[3], wd[3], rd[3];
    logic [3:0]  be[3];
    logic        rdy[3], busy[3], aerr[3];

    int n_checks = 0;
    int n_fail   = 0;
    int lat_of[3] = '{2, 0, 3};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_W (8),
            .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst[g]),
            .MemRead  (mr[g]),
            .MemWrite (mw[g]),
            .addr_mem (addr[g]),
            .write_mem(wd[g]),
`ifdef DMEM_BYTE_LANES_EN
            .byte_en  (be[g]),
`endif
            .read_mem (rd[g]),
            .mem_ready(rdy[g]),
            .mem_busy (busy[g]),
            .addr_err (aerr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, follow it to mem_ready, drop it in the ready cycle.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] b, input string tag);
        int lat, bn;
        mr[d] = !wr; mw[d] = wr; addr[d] = a; wd[d] = data; be[d] = b;
        @(posedge clk); #1;
        lat = 0; bn = 0;
        while (1) begin
            if (busy[d]) bn++;
            if (rdy[d] || lat > 40) break;
            @(posedge clk); #1;
            lat++;
        end
        mr[d] = 1'b0; mw[d] = 1'b0;
        check_eq({tag, "_lat"}, lat, lat_of[d]);
        check_eq({tag, "_busy"}, bn, lat_of[d] + 1);
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, {30'b0, busy[d], rdy[d]}, 32'h0);
    endtask

    task automatic reject_once(input int d, input bit r, input bit w, input logic [31:0] a, input string tag);
        mr[d] = r; mw[d] = w; addr[d] = a; wd[d] = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check_eq({tag, "_err"}, {29'b0, aerr[d], busy[d], rdy[d]}, 32'h4);
        mr[d] = 1'b0; mw[d] = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_err_end"}, {29'b0, aerr[d], busy[d], rdy[d]}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0;
            addr[i] = '0; wd[i] = '0; be[i] = 4'hF;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_read_mem", rd[i], 32'h0);
            check_eq("rst_ready", {31'b0, rdy[i]}, 32'h0);
            check_eq("rst_busy", {31'b0, busy[i]}, 32'h0);
            check_eq("rst_addr_err", {31'b0, aerr[i]}, 32'h0);
            rst[i] = 1'b1;
        end
        @(posedge clk); #1;

        // LATENCY=2 write then read
        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "l2_wr");
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, "l2_rd");
        check_eq("l2_rd_data", rd[0], 32'hDEAD_BEEF);

        // LATENCY=0 preload then back-to-back reads with request held through ready
        xfer(1, 1'b1, 32'h0, 32'h1, 4'hF, "l0_pre0");
        xfer(1, 1'b1, 32'h4, 32'h2, 4'hF, "l0_pre1");
        mr[1] = 1'b1; addr[1] = 32'h0;
        @(posedge clk); #1;
        check_eq("l0_b2b_rdy0", {31'b0, rdy[1]}, 32'h1);
        check_eq("l0_b2b_data0", rd[1], 32'h1);
        addr[1] = 32'h4;
        @(posedge clk); #1;
        check_eq("l0_b2b_gap", {30'b0, busy[1], rdy[1]}, 32'h0);
        @(posedge clk); #1;
        check_eq("l0_b2b_rdy1", {31'b0, rdy[1]}, 32'h1);
        check_eq("l0_b2b_data1", rd[1], 32'h2);
        mr[1] = 1'b0;
        @(posedge clk); #1;

        // Rejections leave RAM and read_mem alone
        xfer(0, 1'b1, 32'h8, 32'h0000_0055, 4'hF, "rej_pre");
        reject_once(0, 1'b1, 1'b0, 32'h13, "rej_misalign");
        reject_once(0, 1'b1, 1'b1, 32'h8, "rej_both");
        check_eq("rej_read_mem_hold", rd[0], 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, "rej_rd");
        check_eq("rej_ram2", rd[0], 32'h0000_0055);

        // Alias: bit 10 lies above the index field for ADDR_W=8
        xfer(0, 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hF, "alias_wr");
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "alias_rd");
        check_eq("alias_data", rd[0], 32'hA5A5_A5A5);

        // LATENCY=3 write abandoned by reset
        xfer(2, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, "l3_pre");
        xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, "l3_prerd");
        check_eq("l3_prerd_data", rd[2], 32'hCAFE_F00D);
        mw[2] = 1'b1; addr[2] = 32'h20; wd[2] = 32'h1234_5678;
        @(posedge clk); #1;
        check_eq("l3_accept_busy", {31'b0, busy[2]}, 32'h1);
        @(posedge clk); #1;
        rst[2] = 1'b0; mw[2] = 1'b0;
        #1;
        check_eq("l3_rst_outs", {rd[2][28:0], aerr[2], busy[2], rdy[2]}, 32'h0);
        check_eq("l3_rst_read_mem", rd[2], 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("l3_rst_no_ready", {30'b0, busy[2], rdy[2]}, 32'h0);
        rst[2] = 1'b1;
        @(posedge clk); #1;
        xfer(2, 1'b0, 32'h20, 32'h0, 4'hF, "l3_postrd");
        check_eq("l3_not_committed", rd[2], 32'hCAFE_F00D);

`ifdef DMEM_BYTE_LANES_EN
        xfer(1, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, "be_full");
        xfer(1, 1'b1, 32'h40, 32'h0000_0000, 4'b0101, "be_mask");
        xfer(1, 1'b0, 32'h40, 32'h0, 4'b0000, "be_rd");
        check_eq("be_data", rd[1], 32'hFF00_FF00);
        xfer(1, 1'b1, 32'h40, 32'h0000_0000, 4'b0000, "be_none");
        xfer(1, 1'b0, 32'h40, 32'h0, 4'hF, "be_rd2");
        check_eq("be_none_data", rd[1], 32'hFF00_FF00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
